control_unit: RTL and testbench

- Instruction register, microstep counter and microcode decoder for the 8-bit bus computer.
- Sits directly upstream of the ALU, RAM, program counter and seven-segment output stages, replacing the DIP-switch control inputs.
- Latches the opcode/operand from the shared bus and drives every stage's control strobes each cycle.
- Drives the operand nibble onto the bus.

---
 rtl/control_unit_if.sv | 35 +++
 rtl/control_unit.sv | 186 ++++++++++++++++++
 tb/tb_control_unit.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/control_unit_if.sv
// -----------------------------------------------------------------------------
// control_unit_if
//   Groups the control unit's flag inputs, control strobes and debug outputs.
//   The shared 8-bit bus is not part of this bundle. It is a tristate net, so
//   it stays a plain inout on the control unit.
//
//   master (control unit): flag_c, flag_z in; strobes, ir_out, step_out out
//   slave  (datapath/bench): the mirror image
//
//   Strobes: hlt mi ri ro io ii ai ao eo su bi oi ce co j fi
//   ir_out   : instruction register contents (debug/LEDs)
//   step_out : current microstep (debug/LEDs)
// -----------------------------------------------------------------------------
interface control_unit_if;
   logic       flag_c;
   logic       flag_z;
   logic       hlt, mi, ri, ro, io, ii, ai, ao;
   logic       eo, su, bi, oi, ce, co, j, fi;
   logic [7:0] ir_out;
   logic [2:0] step_out;

   modport master (
      input  flag_c, flag_z,
      output hlt, mi, ri, ro, io, ii, ai, ao,
      output eo, su, bi, oi, ce, co, j, fi,
      output ir_out, step_out
   );

   modport slave (
      output flag_c, flag_z,
      input  hlt, mi, ri, ro, io, ii, ai, ao,
      input  eo, su, bi, oi, ce, co, j, fi,
      input  ir_out, step_out
   );
endinterface

// File: rtl/control_unit.sv
// -----------------------------------------------------------------------------
// control_unit
//   Instruction register, microstep counter and microcode decoder for the
//   8-bit bus computer. It latches the instruction from the shared bus, steps
//   through STEPS microsteps per instruction, and drives every stage's
//   control strobes combinationally from (ir[7:4], step, halted, flags).
//
//   Ports:
//     clk   : bus clock. All state updates happen on the rising edge.
//     rst   : asynchronous, active-high reset. It clears ir, step and halted.
//     bus   : shared bus. Driven with {4'b0000, ir[3:0]} while io=1,
//             otherwise left high-Z.
//     cu_if : control_unit_if.master. Carries the flags in, and the strobes,
//             ir_out and step_out out.
//
//   Parameter:
//     STEPS : microsteps per instruction, legal range 5..8. Steps after T4
//             are idle.
//
//   Optional feature (macro CTRL_COND_JUMP_EN):
//     When the macro is defined, opcodes JC (0111) and JZ (1000) put the
//     operand on the bus at T2. They assert j only if flag_c or flag_z is set.
//     When the macro is undefined, both opcodes decode as NOP and the flags
//     are ignored.
// -----------------------------------------------------------------------------
module control_unit #(
   parameter int STEPS = 5
) (
   input  logic           clk,
   input  logic           rst,
   inout  wire  [7:0]     bus,
   control_unit_if.master cu_if
);

   localparam logic [2:0] LAST_STEP = 3'(STEPS - 1);

   localparam logic [3:0] OP_LDA = 4'b0001;
   localparam logic [3:0] OP_ADD = 4'b0010;
   localparam logic [3:0] OP_SUB = 4'b0011;
   localparam logic [3:0] OP_STA = 4'b0100;
   localparam logic [3:0] OP_LDI = 4'b0101;
   localparam logic [3:0] OP_JMP = 4'b0110;
   localparam logic [3:0] OP_JC  = 4'b0111;
   localparam logic [3:0] OP_JZ  = 4'b1000;
   localparam logic [3:0] OP_OUT = 4'b1110;
   localparam logic [3:0] OP_HLT = 4'b1111;

   typedef enum logic {ST_RUN, ST_HALT} run_state_e;

   run_state_e state_q, state_d;
   logic [7:0] ir_q, ir_d;
   logic [2:0] step_q, step_d;

   logic hlt, mi, ri, ro, io, ii, ai, ao;
   logic eo, su, bi, oi, ce, co, j, fi;
   logic [3:0] op;

   assign op = ir_q[7:4];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_RUN;
         ir_q    <= 8'h00;
         step_q  <= 3'd0;
      end else begin
         state_q <= state_d;
         ir_q    <= ir_d;
         step_q  <= step_d;
      end
   end

   always_comb begin
      hlt = 1'b0; mi = 1'b0; ri = 1'b0; ro = 1'b0;
      io  = 1'b0; ii = 1'b0; ai = 1'b0; ao = 1'b0;
      eo  = 1'b0; su = 1'b0; bi = 1'b0; oi = 1'b0;
      ce  = 1'b0; co = 1'b0; j  = 1'b0; fi = 1'b0;
      state_d = state_q;
      ir_d    = ir_q;
      step_d  = step_q;

      if (state_q == ST_HALT) begin
         // Once halted, only hlt is asserted until reset.
         hlt = 1'b1;
      end else begin
         case (step_q)
            3'd0: begin
               co = 1'b1; mi = 1'b1;
            end
            3'd1: begin
               ro = 1'b1; ii = 1'b1; ce = 1'b1;
            end
            3'd2: begin
               case (op)
                  OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
                     io = 1'b1; mi = 1'b1;
                  end
                  OP_LDI: begin
                     io = 1'b1; ai = 1'b1;
                  end
                  OP_JMP: begin
                     io = 1'b1; j = 1'b1;
                  end
`ifdef CTRL_COND_JUMP_EN
                  // The operand always goes on the bus, but the PC only
                  // loads it when the flag is set.
                  OP_JC: begin
                     io = 1'b1; j = cu_if.flag_c;
                  end
                  OP_JZ: begin
                     io = 1'b1; j = cu_if.flag_z;
                  end
`endif
                  OP_OUT: begin
                     ao = 1'b1; oi = 1'b1;
                  end
                  OP_HLT: begin
                     hlt = 1'b1;
                  end
                  default: ;
               endcase
            end
            3'd3: begin
               case (op)
                  OP_LDA: begin
                     ro = 1'b1; ai = 1'b1;
                  end
                  OP_ADD, OP_SUB: begin
                     ro = 1'b1; bi = 1'b1;
                  end
                  OP_STA: begin
                     ao = 1'b1; ri = 1'b1;
                  end
                  default: ;
               endcase
            end
            3'd4: begin
               if (op == OP_ADD || op == OP_SUB) begin
                  eo = 1'b1; ai = 1'b1; fi = 1'b1;
                  su = (op == OP_SUB);
               end
            end
            default: ;
         endcase
      end

      // hlt freezes the counter on the same edge that sets the halt state,
      // so step stays at T2.
      if (hlt) begin
         state_d = ST_HALT;
      end else begin
         step_d = (step_q == LAST_STEP) ? 3'd0 : step_q + 3'd1;
      end

      if (ii) begin
         ir_d = bus;
      end
   end

`ifndef CTRL_COND_JUMP_EN
   logic unused_flags;
   assign unused_flags = cu_if.flag_c ^ cu_if.flag_z;
`endif

   assign bus = io ? {4'b0000, ir_q[3:0]} : 8'bzzzz_zzzz;

   assign cu_if.hlt = hlt;
   assign cu_if.mi  = mi;
   assign cu_if.ri  = ri;
   assign cu_if.ro  = ro;
   assign cu_if.io  = io;
   assign cu_if.ii  = ii;
   assign cu_if.ai  = ai;
   assign cu_if.ao  = ao;
   assign cu_if.eo  = eo;
   assign cu_if.su  = su;
   assign cu_if.bi  = bi;
   assign cu_if.oi  = oi;
   assign cu_if.ce  = ce;
   assign cu_if.co  = co;
   assign cu_if.j   = j;
   assign cu_if.fi  = fi;

   assign cu_if.ir_out   = ir_q;
   assign cu_if.step_out = step_q;

endmodule

// File: tb/tb_control_unit.sv
// -----------------------------------------------------------------------------
// tb_control_unit
//   Bench for control_unit with STEPS=5. It acts as the rest of the computer:
//   it drives the bus whenever the control unit is not driving it (io=0), and
//   it drives the flags.
// -----------------------------------------------------------------------------
module tb_control_unit;

   localparam logic [15:0] S_HLT = 16'h8000;
   localparam logic [15:0] S_MI  = 16'h4000;
   localparam logic [15:0] S_RI  = 16'h2000;
   localparam logic [15:0] S_RO  = 16'h1000;
   localparam logic [15:0] S_IO  = 16'h0800;
   localparam logic [15:0] S_II  = 16'h0400;
   localparam logic [15:0] S_AI  = 16'h0200;
   localparam logic [15:0] S_AO  = 16'h0100;
   localparam logic [15:0] S_EO  = 16'h0080;
   localparam logic [15:0] S_SU  = 16'h0040;
   localparam logic [15:0] S_BI  = 16'h0020;
   localparam logic [15:0] S_OI  = 16'h0010;
   localparam logic [15:0] S_CE  = 16'h0008;
   localparam logic [15:0] S_CO  = 16'h0004;
   localparam logic [15:0] S_J   = 16'h0002;
   localparam logic [15:0] S_FI  = 16'h0001;

`ifdef CTRL_COND_JUMP_EN
   localparam logic [15:0] CJ_IO = S_IO;
   localparam logic [15:0] CJ_J  = S_J;
`else
   localparam logic [15:0] CJ_IO = 16'h0000;
   localparam logic [15:0] CJ_J  = 16'h0000;
`endif

   typedef struct {
      logic [7:0]  op;
      logic [2:0]  step;
      logic        fc;
      logic        fz;
      logic [15:0] exp;
   } vec_t;

   typedef struct {
      logic [15:0] strobes;
      logic [2:0]  step;
      logic [7:0]  bus_val;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] tb_val;
   wire  [7:0] bus;
   int         n_cmp = 0;
   int         n_bad = 0;
   exp_t       sb[$];
   vec_t       vecs[19];

   control_unit_if cu_if ();

   control_unit #(.STEPS(5)) dut (
      .clk   (clk),
      .rst   (rst),
      .bus   (bus),
      .cu_if (cu_if)
   );

   always #5 clk = ~clk;

   // The bench acts as the RAM/other bus drivers and backs off while io=1.
   assign bus = cu_if.io ? 8'bzzzz_zzzz : tb_val;

   function automatic logic [15:0] strobes();
      return {cu_if.hlt, cu_if.mi, cu_if.ri, cu_if.ro,
              cu_if.io,  cu_if.ii, cu_if.ai, cu_if.ao,
              cu_if.eo,  cu_if.su, cu_if.bi, cu_if.oi,
              cu_if.ce,  cu_if.co, cu_if.j,  cu_if.fi};
   endfunction

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      #1;
      rst = 1'b0;
   endtask

   task automatic apply_vec(input vec_t v, input int idx);
      exp_t e;
      exp_t got;
      do_reset();
      tb_val       = v.op;
      cu_if.flag_c = v.fc;
      cu_if.flag_z = v.fz;
      for (int k = 0; k < int'(v.step); k++) @(posedge clk);
      #2;
      e.strobes = v.exp;
      e.step    = v.step;
      e.bus_val = ((v.exp & S_IO) != 16'h0) ? {4'h0, v.op[3:0]} : v.op;
      sb.push_back(e);
      got = sb.pop_front();
      check($sformatf("vec%0d_strobes", idx), strobes(), got.strobes);
      check($sformatf("vec%0d_step", idx), 16'(cu_if.step_out), 16'(got.step));
      check($sformatf("vec%0d_bus", idx), 16'(bus), 16'(got.bus_val));
      if (v.step >= 3'd2)
         check($sformatf("vec%0d_ir", idx), 16'(cu_if.ir_out), 16'(v.op));
   endtask

   initial begin
      rst          = 1'b1;
      tb_val       = 8'h00;
      cu_if.flag_c = 1'b0;
      cu_if.flag_z = 1'b0;

      vecs[0]  = '{8'h1E, 3'd0, 1'b0, 1'b0, S_MI | S_CO};
      vecs[1]  = '{8'h1E, 3'd1, 1'b0, 1'b0, S_RO | S_II | S_CE};
      vecs[2]  = '{8'h1E, 3'd2, 1'b0, 1'b0, S_IO | S_MI};
      vecs[3]  = '{8'h1E, 3'd3, 1'b0, 1'b0, S_RO | S_AI};
      vecs[4]  = '{8'h1E, 3'd4, 1'b0, 1'b0, 16'h0000};
      vecs[5]  = '{8'h3F, 3'd4, 1'b0, 1'b0, S_EO | S_AI | S_SU | S_FI};
      vecs[6]  = '{8'h2A, 3'd4, 1'b0, 1'b0, S_EO | S_AI | S_FI};
      vecs[7]  = '{8'h2A, 3'd3, 1'b0, 1'b0, S_RO | S_BI};
      vecs[8]  = '{8'h4C, 3'd3, 1'b0, 1'b0, S_AO | S_RI};
      vecs[9]  = '{8'h55, 3'd2, 1'b0, 1'b0, S_IO | S_AI};
      vecs[10] = '{8'h60, 3'd2, 1'b0, 1'b0, S_IO | S_J};
      vecs[11] = '{8'hE0, 3'd2, 1'b0, 1'b0, S_AO | S_OI};
      vecs[12] = '{8'hF0, 3'd2, 1'b0, 1'b0, S_HLT};
      vecs[13] = '{8'h07, 3'd2, 1'b0, 1'b0, 16'h0000};
      vecs[14] = '{8'h9B, 3'd3, 1'b1, 1'b1, 16'h0000};
      vecs[15] = '{8'h73, 3'd2, 1'b0, 1'b1, CJ_IO};
      vecs[16] = '{8'h73, 3'd2, 1'b1, 1'b0, CJ_IO | CJ_J};
      vecs[17] = '{8'h85, 3'd2, 1'b0, 1'b1, CJ_IO | CJ_J};
      vecs[18] = '{8'h85, 3'd2, 1'b1, 1'b0, CJ_IO};

      // Reset state, before release.
      #2;
      check("reset_strobes", strobes(), S_MI | S_CO);
      check("reset_step", 16'(cu_if.step_out), 16'd0);
      check("reset_ir", 16'(cu_if.ir_out), 16'd0);
      check("reset_bus_undriven", 16'(cu_if.io), 16'd0);
      rst = 1'b0;

      foreach (vecs[i]) apply_vec(vecs[i], i);

      // LDA 14: full walk through the instruction and wrap back to fetch.
      do_reset();
      tb_val = 8'h1E;
      check("lda_t0", strobes(), S_MI | S_CO);
      repeat (2) @(posedge clk);
      #2;
      check("lda_ir", 16'(cu_if.ir_out), 16'h1E);
      check("lda_t2_step", 16'(cu_if.step_out), 16'd2);
      check("lda_t2_bus", 16'(bus), 16'h0E);
      check("lda_t2", strobes(), S_IO | S_MI);
      @(posedge clk); #2;
      check("lda_t3", strobes(), S_RO | S_AI);
      @(posedge clk); #2;
      check("lda_t4", strobes(), 16'h0000);
      @(posedge clk); #2;
      check("lda_wrap_step", 16'(cu_if.step_out), 16'd0);
      check("lda_wrap_strobes", strobes(), S_MI | S_CO);

      // HLT: freeze at T2, then async reset releases it without a clock edge.
      do_reset();
      tb_val = 8'hF0;
      repeat (2) @(posedge clk);
      #2;
      check("hlt_t2", strobes(), S_HLT);
      repeat (10) @(posedge clk);
      #2;
      check("hlt_frozen_step", 16'(cu_if.step_out), 16'd2);
      check("hlt_frozen_strobes", strobes(), S_HLT);
      rst = 1'b1;
      #1;
      check("hlt_async_rst_hlt", 16'(cu_if.hlt), 16'd0);
      check("hlt_async_rst_step", 16'(cu_if.step_out), 16'd0);
      rst = 1'b0;

      // Reset in the middle of an ADD.
      do_reset();
      tb_val = 8'h2A;
      repeat (3) @(posedge clk);
      #2;
      check("mid_add_t3", strobes(), S_RO | S_BI);
      rst = 1'b1;
      #1;
      check("mid_rst_step", 16'(cu_if.step_out), 16'd0);
      check("mid_rst_ir", 16'(cu_if.ir_out), 16'd0);
      check("mid_rst_strobes", strobes(), S_MI | S_CO);
      rst = 1'b0;

      // Random opcodes: check bus-driver exclusivity and tristate behaviour.
      do_reset();
      for (int c = 0; c < 1000; c++) begin
         @(negedge clk);
         if (cu_if.hlt) begin
            rst = 1'b1;
            #1;
            rst = 1'b0;
         end
         tb_val       = 8'($urandom);
         cu_if.flag_c = 1'($urandom);
         cu_if.flag_z = 1'($urandom);
         #1;
         check("rand_one_driver",
               16'($countones({cu_if.co, cu_if.ro, cu_if.io, cu_if.ao, cu_if.eo}) <= 1),
               16'd1);
         if (cu_if.io)
            check("rand_bus_io", 16'(bus), 16'({4'h0, cu_if.ir_out[3:0]}));
         else
            check("rand_bus_z", 16'(bus), 16'(tb_val));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
